// File: rtl/diffusion_lap_scheduler.sv
// diffusion_lap_scheduler
//
// Steps the diffusion engine array through MAX_STEPS consecutive laps. In each
// lap every engine enabled by the captured mask gets a one-cycle start pulse.
// The scheduler then waits until every enabled engine has reported finished,
// and then advances the completed-lap counter. A run is requested by the PS
// through start_i. rst_i aborts or clears a run at any time.
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset, overrides everything
//   start_i         run request, only honoured while idle or done
//   eng_mask_i      engines taking part, captured when a start is accepted
//   eng_finished_i  per-engine finished indication (pulse or level)
//   eng_start_o     registered one-cycle start pulse per enabled engine
//   l_step_o        number of completed laps in the current/last run
//   busy_o          high while a run is in progress
//   done_o          high once all laps of the run have completed

module diffusion_lap_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENGINES = 8,
  parameter int MAX_STEPS   = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [NUM_ENGINES-1:0] eng_mask_i,
  input  logic [NUM_ENGINES-1:0] eng_finished_i,
  output logic [NUM_ENGINES-1:0] eng_start_o,
  output logic [DATA_WIDTH-1:0]  l_step_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_e;

  localparam logic [DATA_WIDTH-1:0] LastStep = DATA_WIDTH'(MAX_STEPS);
  localparam bit NoLaps = (MAX_STEPS == 0);

  state_e                 state_q, state_d;
  logic [NUM_ENGINES-1:0] mask_q, mask_d;
  logic [NUM_ENGINES-1:0] fin_seen_q, fin_seen_d;
  logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
  logic [DATA_WIDTH-1:0]  l_step_q, l_step_d;
  logic                   lap_complete;

  // A lap is complete once every enabled engine has either been seen finished
  // earlier in this lap or is finishing right now. Disabled engines count as
  // finished, so their inputs never matter.
  assign lap_complete = &(fin_seen_q | (eng_finished_i & mask_q) | ~mask_q);

  // Next-state logic. The start pulse is produced one cycle early, so the
  // registered eng_start_q is high exactly during the LAUNCH cycle.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    fin_seen_d  = fin_seen_q;
    l_step_d    = l_step_q;
    eng_start_d = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && (eng_mask_i != '0)) begin
          mask_d     = eng_mask_i;
          l_step_d   = '0;
          fin_seen_d = '0;
          if (NoLaps) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_LAUNCH;
            eng_start_d = eng_mask_i;
          end
        end
      end
      S_LAUNCH: begin
        // Finished inputs in this cycle may still be left over from the
        // previous lap, so they are deliberately not sampled here.
        fin_seen_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        fin_seen_d = fin_seen_q | (eng_finished_i & mask_q);
        if (lap_complete) begin
          state_d  = S_ADVANCE;
          l_step_d = l_step_q + DATA_WIDTH'(1);
        end
      end
      S_ADVANCE: begin
        if (l_step_q == LastStep) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_LAUNCH;
          eng_start_d = mask_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. A reset clears the start pulse too, so a
  // mid-lap abort never re-launches the engines.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      fin_seen_q  <= '0;
      eng_start_q <= '0;
      l_step_q    <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      fin_seen_q  <= fin_seen_d;
      eng_start_q <= eng_start_d;
      l_step_q    <= l_step_d;
    end
  end

  assign eng_start_o = eng_start_q;
  assign l_step_o    = l_step_q;
  assign busy_o      = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_ADVANCE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_diffusion_lap_scheduler.sv
// Testbench for diffusion_lap_scheduler.
// Stimulus runs ahead on its own predicted timeline. It pushes the expected
// start pulses, l_step changes and done rises into queues. A monitor pops
// those queues whenever the DUT shows the corresponding output. A second
// instance with MAX_STEPS=0 covers the zero-lap case.

module tb_diffusion_lap_scheduler;

  localparam int NE   = 8;
  localparam int DW   = 32;
  localparam int MAXS = 7;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    int          aux;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NE-1:0] engMask, engFinished, engStart;
  logic [DW-1:0] lStep;
  logic          busy, done;

  logic          rst0, start0;
  logic [NE-1:0] engMask0, engFinished0, engStart0;
  logic [DW-1:0] lStep0;
  logic          busy0, done0;

  int  cyc = 0;
  int  nChecks = 0;
  int  nFails = 0;
  int  modelStep = 0;
  bit  monOn = 1'b0;
  ev_t startQ[$];
  ev_t stepQ[$];
  ev_t doneQ[$];

  diffusion_lap_scheduler #(.DATA_WIDTH(DW), .NUM_ENGINES(NE), .MAX_STEPS(MAXS)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .eng_mask_i(engMask),
    .eng_finished_i(engFinished), .eng_start_o(engStart), .l_step_o(lStep),
    .busy_o(busy), .done_o(done)
  );

  diffusion_lap_scheduler #(.DATA_WIDTH(DW), .NUM_ENGINES(NE), .MAX_STEPS(0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .start_i(start0), .eng_mask_i(engMask0),
    .eng_finished_i(engFinished0), .eng_start_o(engStart0), .l_step_o(lStep0),
    .busy_o(busy0), .done_o(done0)
  );

  // Free-running clock and cycle counter; cycle n is the period after the nth edge
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever the DUT presents an event, the oldest expectation is popped and compared
  initial begin
    ev_t         e;
    logic [DW-1:0] prevStep;
    logic        prevDone;
    prevStep = '0;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (engStart !== '0) begin
          if (startQ.size() == 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL eng_start: got pulse %0h, expected none (cycle %0d)", engStart, cyc);
          end else begin
            e = startQ.pop_front();
            checkOutput("eng_start_cycle", cyc, e.cyc);
            checkOutput("eng_start_value", 32'(engStart), e.val);
            checkOutput("l_step_at_launch", lStep, e.aux);
            checkOutput("busy_at_launch", 32'(busy), 32'd1);
          end
        end
        if (lStep !== prevStep) begin
          if (stepQ.size() == 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL l_step_change: got %0d, expected no change (cycle %0d)", lStep, cyc);
          end else begin
            e = stepQ.pop_front();
            checkOutput("l_step_change_cycle", cyc, e.cyc);
            checkOutput("l_step_value", lStep, e.val);
          end
        end
        if ((done === 1'b1) && (prevDone !== 1'b1)) begin
          if (doneQ.size() == 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL done_rise: got done=1, expected 0 (cycle %0d)", cyc);
          end else begin
            e = doneQ.pop_front();
            checkOutput("done_cycle", cyc, e.cyc);
            checkOutput("l_step_at_done", lStep, e.val);
            checkOutput("busy_at_done", 32'(busy), 32'd0);
          end
        end
      end
      prevStep = lStep;
      prevDone = done;
    end
  end

  // One run: mode 0 random finish offsets (pulse or level), mode 1 all engines
  // finish in the first wait cycle, mode 2 engines 0..3 finish at 5/9/2/7.
  // abortLap >= 0 asserts reset somewhere inside that lap's wait phase.
  task automatic applyStimulus(input logic [NE-1:0] m, input int mode, input int abortLap);
    int            offs[4] = '{5, 9, 2, 7};
    int            d[NE];
    bit            lvl[NE];
    int            s, l, dMax, abortC;
    bit            aborting;
    logic [NE-1:0] fin;
    tick();
    s = cyc;
    start = 1'b1;
    engMask = m;
    engFinished = NE'($urandom);
    if (modelStep != 0) stepQ.push_back('{s + 1, 32'd0, 0});
    modelStep = 0;
    l = s + 1;
    for (int k = 0; k < MAXS; k++) begin
      dMax = 0;
      for (int i = 0; i < NE; i++) begin
        case (mode)
          0:       d[i] = $urandom_range(1, 6);
          1:       d[i] = 1;
          default: d[i] = (i < 4) ? offs[i] : 1;
        endcase
        lvl[i] = (mode == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
        if (m[i] && (d[i] > dMax)) dMax = d[i];
      end
      startQ.push_back('{l, 32'(m), k});
      aborting = (k == abortLap);
      abortC = aborting ? $urandom_range(1, dMax) : 0;
      if (!aborting) stepQ.push_back('{l + dMax + 1, 32'(k + 1), 0});
      for (int c = 0; c <= dMax + 1; c++) begin
        tick();
        start = ($urandom_range(0, 3) == 0);
        engMask = NE'($urandom);
        fin = NE'($urandom) & ~m;
        if ((c == 0) || (c == dMax + 1)) begin
          fin = fin | (NE'($urandom) & m);
        end else begin
          for (int i = 0; i < NE; i++)
            if (m[i] && (lvl[i] ? (c >= d[i]) : (c == d[i]))) fin[i] = 1'b1;
        end
        engFinished = fin;
        if (aborting && (c == abortC)) begin
          rst = 1'b1;
          if (modelStep != 0) stepQ.push_back('{l + c + 1, 32'd0, 0});
          modelStep = 0;
          tick();
          rst = 1'b0;
          start = 1'b0;
          engFinished = '0;
          checkOutput("busy_after_rst", 32'(busy), 32'd0);
          checkOutput("l_step_after_rst", lStep, 32'd0);
          checkOutput("eng_start_after_rst", 32'(engStart), 32'd0);
          return;
        end
      end
      modelStep = k + 1;
      l = l + dMax + 2;
    end
    doneQ.push_back('{l, 32'(MAXS), 0});
    tick();
    start = 1'b0;
    engFinished = NE'($urandom);
    tick();
    tick();
    checkOutput("done_held", 32'(done), 32'd1);
    checkOutput("l_step_held", lStep, 32'(MAXS));
    checkOutput("busy_in_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; engMask = '0; engFinished = '0;
    rst0 = 1'b1; start0 = 1'b0; engMask0 = '0; engFinished0 = '0;
    repeat (3) tick();
    rst = 1'b0;
    rst0 = 1'b0;
    tick();
    checkOutput("reset_l_step", lStep, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_eng_start", 32'(engStart), 32'd0);
    monOn = 1'b1;

    // Start with an empty mask is ignored while idle
    tick(); start = 1'b1; engMask = '0;
    tick(); start = 1'b0;
    tick();
    checkOutput("mask0_idle_busy", 32'(busy), 32'd0);
    checkOutput("mask0_idle_done", 32'(done), 32'd0);

    // All engines, immediate finishes: done 22 cycles after start
    applyStimulus(8'hFF, 1, -1);

    // Empty-mask start is also ignored in DONE
    tick(); start = 1'b1; engMask = '0;
    tick(); start = 1'b0;
    tick();
    checkOutput("mask0_done_done", 32'(done), 32'd1);
    checkOutput("mask0_done_l_step", lStep, 32'(MAXS));

    // Restart from DONE with a single engine, then the fixed-offset pattern
    applyStimulus(8'h01, 0, -1);
    applyStimulus(8'h0F, 2, -1);

    // Abort in the wait phase of lap 3, then a full clean run
    applyStimulus(8'hA5, 0, 3);
    applyStimulus(8'h3C, 0, -1);

    // Random masks and finish patterns
    for (int r = 0; r < 6; r++) begin
      logic [NE-1:0] rm;
      rm = NE'($urandom_range(1, 255));
      applyStimulus(rm, 0, (r == 2) ? int'($urandom_range(0, MAXS - 1)) : -1);
    end

    // Zero-lap instance: goes straight to DONE without pulsing any engine
    tick(); start0 = 1'b1; engMask0 = 8'h01;
    tick(); start0 = 1'b0;
    checkOutput("zero_laps_done", 32'(done0), 32'd1);
    checkOutput("zero_laps_busy", 32'(busy0), 32'd0);
    checkOutput("zero_laps_eng_start", 32'(engStart0), 32'd0);
    checkOutput("zero_laps_l_step", lStep0, 32'd0);
    tick();
    checkOutput("zero_laps_eng_start_later", 32'(engStart0), 32'd0);

    repeat (4) tick();
    checkOutput("start_queue_drained", 32'(startQ.size()), 32'd0);
    checkOutput("step_queue_drained", 32'(stepQ.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/diffusion_lap_scheduler.md
Name: diffusion_lap_scheduler

Overview:
- Sequences the diffusion engines through consecutive diffusion laps.
- Each lap: issue a start pulse to every enabled engine, collect their finished indications, then advance the lap counter. Repeats until MAX_STEPS laps are done.
- Sits between the PS control registers (start, engine mask, lap readback) and the diffusion engine array.
- Replaces free-running lap counting with an explicit launch/wait/advance handshake.

Parameters:
- DATA_WIDTH, 32, width of the l_step readback.
- NUM_ENGINES, 8, number of diffusion engines sequenced.
- MAX_STEPS, 7, number of laps per run; 0 is legal.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset; driven by PS to abort or clear a run.
- start  in  1  PS run request; sampled only in IDLE and DONE.
- eng_mask  in  NUM_ENGINES  engines taking part in the run; captured on accepted start.
- eng_finished  in  NUM_ENGINES  per-engine finished indication; pulse or level both accepted.
- eng_start  out  NUM_ENGINES  registered one-cycle start pulse to each masked engine.
- l_step  out  DATA_WIDTH  completed-lap count.
- busy  out  1  high in LAUNCH, WAIT and ADVANCE.
- done  out  1  high in DONE.

Behaviour:
- States: IDLE, LAUNCH, WAIT, ADVANCE, DONE. All outputs are registered or decoded from state.
- Reset values: state=IDLE, l_step=0, eng_start=0, fin_seen=0, mask_q=0, busy=0, done=0. rst has priority over every other input in every state, including mid-lap. After a mid-lap reset, engines are not re-pulsed.
- IDLE:
  - If start=1 and eng_mask!=0: capture mask_q=eng_mask, clear l_step=0 and fin_seen=0.
  - Next state is LAUNCH, or DONE if MAX_STEPS==0.
  - If start=1 and eng_mask==0: the request is ignored and the block stays in IDLE.
- LAUNCH (exactly 1 cycle):
  - eng_start=mask_q. Bits for unmasked engines are never asserted.
  - fin_seen is cleared.
  - eng_finished is ignored in this cycle (stale from the previous lap).
  - Next state: WAIT.
- WAIT:
  - Each cycle: fin_seen |= eng_finished & mask_q.
  - Completion condition: (fin_seen | (eng_finished & mask_q) | ~mask_q) is all ones.
  - When the condition holds, go to ADVANCE and increment l_step at that same clock edge.
  - A finished arriving in the same cycle as the last missing one counts; simultaneous finishes are fine.
  - Finished indications from unmasked engines are ignored.
  - No timeout; the block waits indefinitely.
- ADVANCE (1 cycle):
  - If l_step==MAX_STEPS go to DONE, else go to LAUNCH.
  - l_step never exceeds MAX_STEPS. Arithmetic is unsigned at DATA_WIDTH, with no wrap possible given that bound.
- DONE:
  - done=1 and l_step is held.
  - start=1 behaves as in IDLE: the run restarts, l_step is cleared, and the next state is LAUNCH (or DONE again if MAX_STEPS==0). The mask==0 rule also applies.
  - Otherwise the block stays in DONE until rst.
- eng_mask changes during a run have no effect until the next accepted start.
- start while busy is ignored.
- Per-lap latency: 1 (LAUNCH) + wait cycles + 1 (ADVANCE).
  - Engine finishing in the first WAIT cycle: eng_start at cycle t, l_step increments at edge t+2, next eng_start at t+3.
- Run of N laps with immediate finishes: start at cycle 0, done=1 at cycle 3N+1.

Test Plan:
- Reset, then start with mask=8'hFF, all engines pulse eng_finished in the first WAIT cycle -> eng_start=8'hFF for 7 laps, l_step steps 1..7, done=1 at cycle 22, then held at 7.
- mask=8'h0F, engines 0-3 finish on cycles 5/9/2/7 after LAUNCH, engines 4-7 never finish -> each lap advances 9 cycles after LAUNCH, eng_start[7:4] always 0.
- eng_finished held high from the previous lap and present during LAUNCH -> ignored; l_step does not advance until a fresh WAIT-cycle finished is seen.
- rst asserted in WAIT with l_step=3 -> next cycle state=IDLE, l_step=0, busy=0, no eng_start. A later start runs a full 7 laps.
- start with mask=0 -> remains IDLE, busy=0. With MAX_STEPS=0 and mask=1 -> done=1 one cycle after start, no eng_start.
- In DONE, pulse start with mask=8'h01 -> l_step=0, LAUNCH next cycle, new 7-lap run completes. start pulsed during WAIT -> no effect.
